// File: rtl/oc8051_ram_bitrmw.sv
// oc8051 data RAM: synchronous read, bit-addressed read-modify-write stores, write-to-read forwarding, clear sweep.
// Define OC8051_RAM_PARITY_EN to store an even-parity bit per word and flag read parity errors.
module oc8051_ram_bitrmw #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter logic [AW-1:0] BIT_BASE = 8'h20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_bit,
  output logic [DW-1:0] rd_data,
  output logic          rd_bit_data,
  output logic          rd_par_err,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_bit,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_bit_data
);
  localparam int BW = $clog2(DW);
  localparam int PW = AW - 1 - BW;
  localparam int DEPTH = 2 ** AW;
`ifdef OC8051_RAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // Low half of the bit space maps into BIT_BASE upward (wrapping); high half hits every 2**BW-th word.
  function automatic logic [AW-1:0] word_of(input logic [AW-1:0] a, input logic is_bit);
    logic [PW-1:0] p;
    p = a[AW-2:BW];
    if (!is_bit) begin
      return a;
    end else if (a[AW-1]) begin
      return {1'b1, p, {BW{1'b0}}};
    end else begin
      return BIT_BASE + {{(BW + 1){1'b0}}, p};
    end
  endfunction

  function automatic logic even_par(input logic [DW-1:0] d);
    return ^d;
  endfunction

  logic [MW-1:0] mem [DEPTH];

  state_t        state_r, state_next_s;
  logic [AW-1:0] cnt_r, cnt_next_s;
  logic          busy_r, sweep_we_s;
  logic [DW-1:0] rd_data_r, rd_next_s, merged_s;
  logic          rd_bit_r, par_mis_r, fwd_r, par_mis_s, fwd_s, wr_ok_s;
  logic [AW-1:0] rd_word_s, wr_word_s;
  logic [BW-1:0] rd_idx_s, wr_idx_s;
  logic [MW-1:0] mem_rd_s, wr_store_s;

  // Clear-sweep next state: clr always restarts from word 0; otherwise zero one word per cycle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    sweep_we_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr) begin
          state_next_s = SWEEP;
          cnt_next_s   = {AW{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      SWEEP: begin
        if (clr) begin
          cnt_next_s = {AW{1'b0}};
        end else begin
          sweep_we_s = 1'b1;
          cnt_next_s = cnt_r + {{(AW - 1){1'b0}}, 1'b1};
          if (cnt_r == {AW{1'b1}}) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = SWEEP;
          end
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {AW{1'b0}};
      end
    endcase
  end

  // Sweep state and counter; reset starts a full sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SWEEP;
      cnt_r   <= {AW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s == SWEEP);
    end
  end

  // Address decode, merge of bit writes onto the current read word, forwarding and read-data selection.
  always_comb begin
    rd_word_s = word_of(rd_addr, rd_bit);
    wr_word_s = word_of(wr_addr, wr_bit);
    rd_idx_s  = rd_bit ? rd_addr[BW-1:0] : {BW{1'b0}};
    wr_idx_s  = wr_addr[BW-1:0];
    wr_ok_s   = wr & ~busy_r;
    mem_rd_s  = mem[rd_word_s];
    merged_s  = wr_data;
    if (wr_bit) begin
      merged_s           = rd_data_r;
      merged_s[wr_idx_s] = wr_bit_data;
    end else begin
      merged_s = wr_data;
    end
`ifdef OC8051_RAM_PARITY_EN
    wr_store_s = {even_par(merged_s), merged_s};
    par_mis_s  = ~busy_r & (^mem_rd_s);
`else
    wr_store_s = merged_s;
    par_mis_s  = 1'b0;
`endif
    fwd_s = wr_ok_s && (wr_word_s == rd_word_s);
    if (busy_r) begin
      rd_next_s = {DW{1'b0}};
    end else if (fwd_s) begin
      rd_next_s = merged_s;
    end else begin
      rd_next_s = mem_rd_s[DW-1:0];
    end
  end

  // Read-side output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {DW{1'b0}};
      rd_bit_r  <= 1'b0;
      par_mis_r <= 1'b0;
      fwd_r     <= 1'b0;
    end else begin
      rd_data_r <= rd_next_s;
      rd_bit_r  <= rd_next_s[rd_idx_s];
      par_mis_r <= par_mis_s;
      fwd_r     <= fwd_s;
    end
  end

  // Single array write port; the sweep owns it while busy, so user writes are dropped then.
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      mem[cnt_r] <= {MW{1'b0}};
    end else if (wr_ok_s) begin
      mem[wr_word_s] <= wr_store_s;
    end
  end

  assign busy        = busy_r;
  assign rd_data     = rd_data_r;
  assign rd_bit_data = rd_bit_r;
  // Forwarded words carry freshly computed parity, so a stale stored error is masked.
  assign rd_par_err  = par_mis_r & ~fwd_r;

endmodule

// File: doc/oc8051_ram_bitrmw.md
Name: oc8051_ram_bitrmw

Overview:
- Parametrised on-chip data RAM for the oc8051 core: one synchronous read port and one write port; configurable data width and depth.
- Bit-addressed reads and read-modify-write bit stores; same-cycle write-to-read forwarding.
- Hardware clear sweep that zeroes the whole array after reset or on request.
- Sits between the ALU/decoder write path and the RAM read-select mux.

Parameters:
- DW, 8, data word width; power of two, 8..32; BW = log2(DW) is the bit-index width.
- AW, 8, address width; depth = 2**AW words; AW > BW+1.
- BIT_BASE, 8'h20, word address of the low bit-addressable region; AW bits wide.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clr  in  1  pulse: restart the clear sweep
- busy  out  1  clear sweep in progress
- rd_addr  in  AW  read address (word address, or bit address if rd_bit)
- rd_bit  in  1  rd_addr is a bit address
- rd_data  out  DW  read word, 1-cycle latency
- rd_bit_data  out  1  selected bit of rd_data
- rd_par_err  out  1  parity error on current rd_data
- wr  in  1  write strobe
- wr_addr  in  AW  write address (word, or bit if wr_bit)
- wr_bit  in  1  bit write
- wr_data  in  DW  word write data
- wr_bit_data  in  1  bit write value

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All state is on posedge clk.
- Reset values: rd_data=0, rd_bit_data=0, rd_par_err=0, busy=1, sweep counter=0, forward flag=0.
- Address map for bit address A, with P = A[AW-2:BW]:
  - A[AW-1]=0: word = BIT_BASE + P, modulo 2**AW.
  - A[AW-1]=1: word = {1'b1, P, BW'b0}.
  - Bit index = A[BW-1:0].
  - Word accesses use the address unchanged.
- Read latency is 1 cycle.
  - rd_data(N+1) = mem[rd_word(N)], unless forwarded.
  - rd_bit_data(N+1) = rd_data(N+1)[bit index registered at N]; it is rd_data[0] for word reads.
- Forwarding: if wr is accepted in cycle N and its word address equals the read word address in N, then rd_data(N+1) = the merged write data of cycle N.
- Bit write (wr & wr_bit in cycle N): merged word = rd_data(N) with the bit at index wr_addr[BW-1:0] replaced by wr_bit_data.
  - Caller contract: a bit read of the same bit address is issued in N-1.
  - The contract is not checked; a violation writes stale neighbour bits.
- Word write: merged word = wr_data.
- Clear sweep FSM:
  - IDLE: busy=0. clr=1 goes to SWEEP with cnt=0.
  - SWEEP: busy=1. Write 0 to mem[cnt], cnt++. After cnt = 2**AW-1 is written, go to IDLE; busy falls the following cycle.
  - Sweep length is exactly 2**AW cycles after rst release.
  - clr during SWEEP restarts at cnt=0.
  - rst mid-sweep restarts the sweep after release.
- While busy:
  - User wr is dropped (no array update).
  - Reads return rd_data=0 and rd_par_err=0.
  - Forwarding is disabled.
- Boundaries:
  - BIT_BASE + P wraps modulo depth.
  - A write and read of the same word in one cycle always forwards.
  - Back-to-back bit writes to the same word: the second write merges onto the forwarded result of the first.
- Each bit write stores exactly one bit; the other DW-1 bits equal the rd_data used for the merge.

Optional Feature:
- Macro: OC8051_RAM_PARITY_EN.
- Defined:
  - Array is DW+1 bits; stored bit DW = even parity of the data (XOR of all bits), computed on the merged word.
  - On a read, rd_par_err(N+1)=1 when the stored parity mismatches the data.
  - Forwarded reads recompute parity, so they never error.
  - The sweep writes parity 0.
- Undefined: array is DW bits and rd_par_err is tied 0. The port is always present.

Test Plan:
- Release rst; count cycles -> busy=1 for exactly 256 cycles (AW=8), then 0. Read 8'h7F -> rd_data=0.
- Word write 8'hA5 to 8'h30, then read 8'h30 next cycle -> rd_data=8'hA5, rd_par_err=0.
- Bit read 8'h0B, then bit write 8'h0B with wr_bit_data=1, then word read 8'h21 -> 8'h08. Bit address 8'h83 write 1 -> word 8'h80 = 8'h08.
- Read and write 8'h40 with 8'h3C in the same cycle -> rd_data=8'h3C next cycle (forwarded).
- Assert clr at sweep count 100 -> busy stays 1 for 256 further cycles. wr during busy -> location still 0 afterwards.
- With PARITY_EN: force-flip the stored bit 0 at 8'h50 (holding 8'h01) -> read gives rd_data=8'h00, rd_par_err=1.
